pipe_ctrl: RTL and testbench

- Centralised pipeline control unit for the N-stage RISC-V core.
- Owns per-stage advance enables and bubble-insert (flush) controls, load-use interlock with configurable stall depth, branch/jump redirect flushing from a configurable resolve stage, and a halt-drain state machine.
- Halting is enable-based: the core clock runs free and older instructions retire before `halt` asserts.
- Sits beside the stage modules at core top level and also exposes saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Holds the FSM state encoding, stage indices and parameter legality checks.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  localparam int unsigned NUM_STAGES_DEF = STG_WB + 1;
  localparam int unsigned LU_STALL_MAX   = 4;
  localparam int unsigned STALL_CNT_W    = 2;

  // Resolve stage must lie at or after EX and be a real stage; stall depth 1..4.
  function automatic bit params_legal(input int unsigned num_stages,
                                      input int unsigned resolve_stage,
                                      input int unsigned lu_stall,
                                      input int unsigned addr_w,
                                      input int unsigned cnt_w);
    return (num_stages > STG_EX) &&
           (resolve_stage >= STG_EX) && (resolve_stage <= num_stages - 1) &&
           (lu_stall >= 1) && (lu_stall <= LU_STALL_MAX) &&
           (addr_w >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones once reached; cleared only by reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control: per-stage advance/flush, load-use interlock,
// branch redirect flushing and an enable-based halt-drain state machine.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES         = NUM_STAGES_DEF,
  parameter int unsigned BCH_RESOLVE_STAGE  = 3,
  parameter int unsigned LOAD_USE_STALL_CYC = 1,
  parameter int unsigned REG_ADDR_WIDTH     = 5,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_use,
  input  logic                      id_rs2_use,
  input  logic                      id_halt,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_rd_wen,
  input  logic                      ex_is_load,
  input  logic                      redirect_en,
  output logic                      pc_en,
  output logic [NUM_STAGES-1:0]     stage_en,
  output logic [NUM_STAGES-1:0]     stage_flush,
  output logic                      halt,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int unsigned DRAIN_W = $clog2(NUM_STAGES);
  localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(LOAD_USE_STALL_CYC - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(NUM_STAGES - 2);

  if (!params_legal(NUM_STAGES, BCH_RESOLVE_STAGE, LOAD_USE_STALL_CYC,
                    REG_ADDR_WIDTH, CNT_WIDTH)) begin : g_param_err
    $error("pipe_ctrl: illegal parameter combination");
  end

  state_e                   state, state_nxt;
  logic [STALL_CNT_W-1:0]   stall_cnt, stall_cnt_nxt;
  logic [DRAIN_W-1:0]       drain_cnt, drain_cnt_nxt;
  logic [NUM_STAGES-1:0]    redirect_mask;
  logic                     load_use;
  logic                     stall_inc;
  logic                     flush_inc;

  // Stages 1..BCH_RESOLVE_STAGE hold younger, wrong-path instructions on a redirect.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_mask
    assign redirect_mask[i] = (i >= 1) && (i <= BCH_RESOLVE_STAGE);
  end

  assign load_use = id_valid && ex_is_load && ex_rd_wen && (ex_rd != '0) &&
                    ((id_rs1_use && (id_rs1 == ex_rd)) ||
                     (id_rs2_use && (id_rs2 == ex_rd)));

  assign halt = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    drain_cnt_nxt = drain_cnt;
    pc_en         = 1'b1;
    stage_en      = '1;
    stage_flush   = '0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state)
      RUN: begin
        if (redirect_en) begin
          stage_flush   = redirect_mask;
          stall_cnt_nxt = '0;
          flush_inc     = 1'b1;
        end else if ((stall_cnt != '0) || load_use) begin
          // A hazard seen while bubbles remain does not restart the count.
          pc_en               = 1'b0;
          stage_en[STG_IF]    = 1'b0;
          stage_en[STG_ID]    = 1'b0;
          stage_flush[STG_EX] = 1'b1;
          stall_inc           = 1'b1;
          stall_cnt_nxt       = (stall_cnt != '0) ? stall_cnt - STALL_CNT_W'(1)
                                                  : STALL_LOAD;
        end else if (id_valid && id_halt) begin
          pc_en            = 1'b0;
          stage_en[STG_IF] = 1'b0;
          state_nxt        = DRAIN;
          drain_cnt_nxt    = DRAIN_LOAD;
        end
      end

      DRAIN: begin
        if (redirect_en) begin
          // Halt sat on a wrong path behind an older taken branch.
          stage_flush   = redirect_mask;
          stall_cnt_nxt = '0;
          flush_inc     = 1'b1;
          state_nxt     = RUN;
        end else begin
          pc_en               = 1'b0;
          stage_en[STG_IF]    = 1'b0;
          stage_en[STG_ID]    = 1'b0;
          stage_flush[STG_EX] = 1'b1;
          drain_cnt_nxt       = drain_cnt - DRAIN_W'(1);
          if (drain_cnt <= DRAIN_W'(1)) begin
            state_nxt = HALTED;
          end
        end
      end

      HALTED: begin
        pc_en    = 1'b0;
        stage_en = '0;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (stall depth 1 and 3) share
// stimulus; a behavioural model queues expectations, a monitor pops and checks.
module tb_pipe_ctrl;

  localparam int NS      = 5;
  localparam int RES     = 3;
  localparam int CNT_MAX = 65535;

  typedef struct {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_use;
    logic       rs2_use;
    logic       id_halt;
    logic [4:0] ex_rd;
    logic       ex_rd_wen;
    logic       ex_is_load;
    logic       redirect;
    logic       rst;
  } in_t;

  typedef struct {
    int         cyc;
    logic       pc_en;
    logic [4:0] en_eff;
    logic [4:0] flush;
    logic       halt;
    int         stall_cycles;
    int         flush_count;
  } exp_t;

  typedef struct {
    bit halted;
    bit draining;
    int drain_left;
    int stall_left;
    int stall_cycles;
    int flush_count;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_rs1_use = 1'b0, id_rs2_use = 1'b0, id_halt = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_rd_wen = 1'b0, ex_is_load = 1'b0, redirect_en = 1'b0;

  logic        pc_en1, pc_en3, halt1, halt3;
  logic [4:0]  stage_en1, stage_en3, stage_flush1, stage_flush3;
  logic [15:0] stall_cycles1, stall_cycles3, flush_count1, flush_count3;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q1[$];
  exp_t q3[$];
  mdl_t m1, m3;

  always #5 clk = ~clk;

  pipe_ctrl #(.NUM_STAGES(NS), .BCH_RESOLVE_STAGE(RES), .LOAD_USE_STALL_CYC(1),
              .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_halt(id_halt),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
    .redirect_en(redirect_en), .pc_en(pc_en1), .stage_en(stage_en1),
    .stage_flush(stage_flush1), .halt(halt1), .stall_cycles(stall_cycles1),
    .flush_count(flush_count1));

  pipe_ctrl #(.NUM_STAGES(NS), .BCH_RESOLVE_STAGE(RES), .LOAD_USE_STALL_CYC(3),
              .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_halt(id_halt),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
    .redirect_en(redirect_en), .pc_en(pc_en3), .stage_en(stage_en3),
    .stage_flush(stage_flush3), .halt(halt3), .stall_cycles(stall_cycles3),
    .flush_count(flush_count3));

  task automatic cmp(input string what, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", what, c, act, exp);
    end
  endtask

  function automatic in_t idle_in();
    in_t x;
    x.id_valid = 1'b0; x.rs1 = '0; x.rs2 = '0; x.rs1_use = 1'b0; x.rs2_use = 1'b0;
    x.id_halt = 1'b0; x.ex_rd = '0; x.ex_rd_wen = 1'b0; x.ex_is_load = 1'b0;
    x.redirect = 1'b0; x.rst = 1'b0;
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.id_valid   = 1'($urandom_range(0, 3) != 0);
    x.rs1        = 5'($urandom_range(0, 3));
    x.rs2        = 5'($urandom_range(0, 3));
    x.rs1_use    = 1'($urandom_range(0, 1));
    x.rs2_use    = 1'($urandom_range(0, 1));
    x.id_halt    = 1'($urandom_range(0, 15) == 0);
    x.ex_rd      = 5'($urandom_range(0, 3));
    x.ex_rd_wen  = 1'($urandom_range(0, 3) != 0);
    x.ex_is_load = 1'($urandom_range(0, 1));
    x.redirect   = 1'($urandom_range(0, 7) == 0);
    x.rst        = 1'b0;
    return x;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Reference behaviour: one pipeline cycle, from the documented priority rules.
  task automatic model_step(input in_t x, input int lus, inout mdl_t m, output exp_t e);
    mdl_t n;
    bit   haz;
    if (x.rst) m = '{default: 0};
    n   = m;
    haz = x.id_valid && x.ex_is_load && x.ex_rd_wen && (x.ex_rd != 0) &&
          ((x.rs1_use && x.rs1 == x.ex_rd) || (x.rs2_use && x.rs2 == x.ex_rd));
    e.cyc = cyc;
    e.pc_en = 1'b1; e.en_eff = 5'b11111; e.flush = 5'b00000; e.halt = m.halted;
    e.stall_cycles = m.stall_cycles; e.flush_count = m.flush_count;
    if (m.halted) begin
      e.pc_en = 1'b0; e.en_eff = 5'b00000;
    end else if (x.redirect) begin
      for (int i = 1; i <= RES; i++) e.flush[i] = 1'b1;
      e.en_eff = ~e.flush;
      n.draining = 0; n.stall_left = 0;
      n.flush_count = sat_inc(m.flush_count);
    end else if (m.draining) begin
      e.pc_en = 1'b0; e.flush = 5'b00100; e.en_eff = 5'b11000;
      n.drain_left = m.drain_left - 1;
      if (n.drain_left == 0) begin n.draining = 0; n.halted = 1; end
    end else if (m.stall_left > 0 || haz) begin
      e.pc_en = 1'b0; e.flush = 5'b00100; e.en_eff = 5'b11000;
      n.stall_left = (m.stall_left > 0) ? m.stall_left - 1 : lus - 1;
      n.stall_cycles = sat_inc(m.stall_cycles);
    end else if (x.id_valid && x.id_halt) begin
      e.pc_en = 1'b0; e.en_eff = 5'b11110;
      n.draining = 1; n.drain_left = NS - 2;
    end
    if (!x.rst) m = n;
  endtask

  task automatic drive(input in_t x);
    exp_t e1, e3;
    @(posedge clk);
    #1;
    rst = x.rst; id_valid = x.id_valid; id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_rs1_use = x.rs1_use; id_rs2_use = x.rs2_use; id_halt = x.id_halt;
    ex_rd = x.ex_rd; ex_rd_wen = x.ex_rd_wen; ex_is_load = x.ex_is_load;
    redirect_en = x.redirect;
    model_step(x, 1, m1, e1);
    model_step(x, 3, m3, e3);
    q1.push_back(e1);
    q3.push_back(e3);
    cyc++;
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic pc,
                           input logic [4:0] en, input logic [4:0] fl, input logic h,
                           input logic [15:0] sc, input logic [15:0] fc);
    cmp({tag, ".pc_en"}, e.cyc, int'(pc), int'(e.pc_en));
    cmp({tag, ".stage_en_eff"}, e.cyc, int'(en & ~fl), int'(e.en_eff));
    cmp({tag, ".stage_flush"}, e.cyc, int'(fl), int'(e.flush));
    cmp({tag, ".halt"}, e.cyc, int'(h), int'(e.halt));
    cmp({tag, ".stall_cycles"}, e.cyc, int'(sc), e.stall_cycles);
    cmp({tag, ".flush_count"}, e.cyc, int'(fc), e.flush_count);
  endtask

  // Monitor: outputs are presented every cycle; check them mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_out("lus1", e, pc_en1, stage_en1, stage_flush1, halt1, stall_cycles1, flush_count1);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check_out("lus3", e, pc_en3, stage_en3, stage_flush3, halt3, stall_cycles3, flush_count3);
      end
    end
  end

  initial begin
    in_t x, hz;
    m1 = '{default: 0};
    m3 = '{default: 0};

    hz = idle_in();
    hz.id_valid = 1'b1; hz.rs1 = 5'd5; hz.rs1_use = 1'b1; hz.rs2 = 5'd7;
    hz.ex_rd = 5'd5; hz.ex_rd_wen = 1'b1; hz.ex_is_load = 1'b1;

    // Reset, then idle outputs.
    x = idle_in(); x.rst = 1'b1;
    repeat (2) drive(x);
    repeat (2) drive(idle_in());

    // Load-use on rs1, hazard held one extra cycle, then idle.
    repeat (2) drive(hz);
    repeat (4) drive(idle_in());
    // Same on rs2.
    x = hz; x.rs1_use = 1'b0; x.rs2_use = 1'b1; x.rs2 = 5'd5;
    drive(x);
    repeat (4) drive(idle_in());

    // Load to x0, and load without write enable: no stall.
    x = hz; x.rs1 = 5'd0; x.ex_rd = 5'd0;
    drive(x);
    x = hz; x.ex_rd_wen = 1'b0;
    drive(x);

    // Redirect coinciding with a hazard.
    x = hz; x.redirect = 1'b1;
    drive(x);
    drive(idle_in());

    // Reset mid-stall leaves no residual bubbles.
    drive(hz);
    x = hz; x.rst = 1'b1;
    drive(x);
    repeat (3) drive(idle_in());

    // Halt: entry, three drain cycles, then sticky under random inputs.
    x = idle_in(); x.id_valid = 1'b1; x.id_halt = 1'b1;
    drive(x);
    repeat (3) drive(idle_in());
    repeat (21) drive(rand_in());

    // Asynchronous reset out of HALTED.
    x = idle_in(); x.rst = 1'b1;
    drive(x);
    drive(idle_in());

    // Redirect on the second drain cycle cancels the halt.
    x = idle_in(); x.id_valid = 1'b1; x.id_halt = 1'b1;
    drive(x);
    drive(idle_in());
    x = idle_in(); x.redirect = 1'b1;
    drive(x);
    repeat (6) drive(idle_in());

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      x = rand_in();
      if (m1.halted && m3.halted && $urandom_range(0, 3) == 0) x.rst = 1'b1;
      else if ($urandom_range(0, 99) == 0) x.rst = 1'b1;
      drive(x);
    end
    drive(idle_in());

    for (int i = 0; i < 10 && (q1.size() > 0 || q3.size() > 0); i++) @(negedge clk);
    #1;
    if (q1.size() > 0 || q3.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_queues pending=%0d expected=0", q1.size() + q3.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
